// File: rtl/regfile_mp.sv
// ---------------------------------------------------------------------------
// regfile_mp -- multi-port register file for the Simple RISC Machine datapath.
//
// One synchronous write port, two combinational read ports (ALU operands A/B)
// and a sequenced clear sweep that zeroes one register per clock.
//
// Ports:
//   clk         clock; all state changes on the rising edge
//   rst_n       asynchronous active-low reset
//   data_in     write data
//   writenum    write register index
//   write       write enable (ignored while busy)
//   readnum_a   read index, port A
//   readnum_b   read index, port B
//   clear       start a clear sweep (ignored while busy)
//   data_out_a  register[readnum_a], combinational; 0 for an index >= NREGS
//   data_out_b  register[readnum_b], combinational; 0 for an index >= NREGS
//   busy        clear sweep in progress (high for exactly NREGS cycles)
//
// Build option:
//   REGFILE_BYPASS_EN  when defined, a read port whose index matches an
//                      accepted write in the same cycle returns data_in
//                      (write-through forwarding). Off by default.
// ---------------------------------------------------------------------------
module regfile_mp #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic [ADDR_W-1:0] writenum,
    input  logic              write,
    input  logic [ADDR_W-1:0] readnum_a,
    input  logic [ADDR_W-1:0] readnum_b,
    input  logic              clear,
    output logic [DATA_W-1:0] data_out_a,
    output logic [DATA_W-1:0] data_out_b,
    output logic              busy
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);
    localparam logic [ADDR_W:0]   NREGS_W  = (ADDR_W + 1)'(NREGS);

    state_t            state_r;
    state_t            state_nx_s;
    logic [ADDR_W-1:0] ptr_r;
    logic [ADDR_W-1:0] ptr_nx_s;
    logic              busy_r;
    logic              busy_nx_s;
    logic [DATA_W-1:0] regs_r [NREGS];
    logic              wr_en_s;
    logic [DATA_W-1:0] stored_a_s;
    logic [DATA_W-1:0] stored_b_s;

    // Write acceptance: only in IDLE and only for an existing register.
    always_comb begin
        wr_en_s = 1'b0;
        if ((state_r == ST_IDLE) && write && ({1'b0, writenum} < NREGS_W)) begin
            wr_en_s = 1'b1;
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Sweep FSM next-state logic; the pointer stops at LAST_IDX and never wraps.
    always_comb begin
        state_nx_s = state_r;
        ptr_nx_s   = ptr_r;
        busy_nx_s  = busy_r;
        case (state_r)
            ST_IDLE: begin
                if (clear) begin
                    state_nx_s = ST_SWEEP;
                    ptr_nx_s   = {ADDR_W{1'b0}};
                    busy_nx_s  = 1'b1;
                end else begin
                    busy_nx_s  = 1'b0;
                end
            end
            ST_SWEEP: begin
                if (ptr_r == LAST_IDX) begin
                    state_nx_s = ST_IDLE;
                    ptr_nx_s   = {ADDR_W{1'b0}};
                    busy_nx_s  = 1'b0;
                end else begin
                    ptr_nx_s   = ptr_r + ADDR_W'(1);
                    busy_nx_s  = 1'b1;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
                ptr_nx_s   = {ADDR_W{1'b0}};
                busy_nx_s  = 1'b0;
            end
        endcase
    end

    // Sweep FSM state, pointer and busy flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            ptr_r   <= {ADDR_W{1'b0}};
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            ptr_r   <= ptr_nx_s;
            busy_r  <= busy_nx_s;
        end
    end

    // Register array: sweep clear takes the pointed entry, otherwise accepted writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if ((state_r == ST_SWEEP) && (ptr_r == ADDR_W'(i))) begin
                    regs_r[i] <= {DATA_W{1'b0}};
                end else if (wr_en_s && (writenum == ADDR_W'(i))) begin
                    regs_r[i] <= data_in;
                end else begin
                    regs_r[i] <= regs_r[i];
                end
            end
        end
    end

    // Read muxes; an index with no matching register falls through to zero.
    always_comb begin
        stored_a_s = {DATA_W{1'b0}};
        stored_b_s = {DATA_W{1'b0}};
        for (int i = 0; i < NREGS; i++) begin
            stored_a_s = (readnum_a == ADDR_W'(i)) ? regs_r[i] : stored_a_s;
            stored_b_s = (readnum_b == ADDR_W'(i)) ? regs_r[i] : stored_b_s;
        end
    end

    // Output selection, with optional same-cycle forwarding of an accepted write.
    always_comb begin
        data_out_a = stored_a_s;
        data_out_b = stored_b_s;
`ifdef REGFILE_BYPASS_EN
        if (wr_en_s && (readnum_a == writenum)) begin
            data_out_a = data_in;
        end else begin
            data_out_a = stored_a_s;
        end
        if (wr_en_s && (readnum_b == writenum)) begin
            data_out_b = data_in;
        end else begin
            data_out_b = stored_b_s;
        end
`else
        data_out_a = stored_a_s;
        data_out_b = stored_b_s;
`endif
    end

    assign busy = busy_r;

endmodule

// File: tb/tb_regfile_mp.sv
// ---------------------------------------------------------------------------
// tb_regfile_mp -- self-checking bench for regfile_mp (default parameters).
// A bench-side register model produces expected read values, which are queued
// when a read is driven and popped when the outputs are sampled.
// ---------------------------------------------------------------------------
module tb_regfile_mp;

    logic        clk;
    logic        rst_n;
    logic [15:0] data_in;
    logic [2:0]  writenum;
    logic        write;
    logic [2:0]  readnum_a;
    logic [2:0]  readnum_b;
    logic        clear;
    logic [15:0] data_out_a;
    logic [15:0] data_out_b;
    logic        busy;

    logic [15:0] mdl [8];
    logic [15:0] exp_q [$];
    int          vectors;
    int          miscompares;

    regfile_mp #(.DATA_W(16), .NREGS(8), .ADDR_W(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .writenum   (writenum),
        .write      (write),
        .readnum_a  (readnum_a),
        .readnum_b  (readnum_b),
        .clear      (clear),
        .data_out_a (data_out_a),
        .data_out_b (data_out_b),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run time exceeded");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) mdl[i] = 16'h0000;
    endtask

    task automatic do_write(input logic [2:0] addr, input logic [15:0] data);
        write    = 1'b1;
        writenum = addr;
        data_in  = data;
        tick();
        write    = 1'b0;
        mdl[addr] = data;
    endtask

    // Drive read indices, queue the model's expectations, then pop and compare.
    task automatic read_chk(input string tag, input logic [2:0] ra, input logic [2:0] rb);
        readnum_a = ra;
        readnum_b = rb;
        exp_q.push_back(mdl[ra]);
        exp_q.push_back(mdl[rb]);
        #1;
        check({tag, "_a"}, data_out_a, exp_q.pop_front());
        check({tag, "_b"}, data_out_b, exp_q.pop_front());
    endtask

    task automatic read_all(input string tag);
        for (int i = 0; i < 8; i += 2) read_chk(tag, 3'(i), 3'(i + 1));
    endtask

    initial begin
        int cnt;
        vectors     = 0;
        miscompares = 0;
        rst_n     = 1'b0;
        data_in   = 16'h0000;
        writenum  = 3'd0;
        write     = 1'b0;
        readnum_a = 3'd0;
        readnum_b = 3'd0;
        clear     = 1'b0;
        model_clear();

        // Reset state
        #12;
        check("rst_busy", {15'd0, busy}, 16'h0000);
        read_all("rst");
        rst_n = 1'b1;
        tick();

        // Async reset mid-cycle clears everything without a clock edge
        do_write(3'd6, 16'h7777);
        do_write(3'd0, 16'h0101);
        read_chk("pre_rst", 3'd6, 3'd0);
        #2;
        rst_n = 1'b0;
        model_clear();
        #1;
        check("async_rst_busy", {15'd0, busy}, 16'h0000);
        read_chk("async_rst", 3'd6, 3'd0);
        #1;
        rst_n = 1'b1;
        tick();

        // Write then hold: a register is not overwritten while write=0
        do_write(3'd1, 16'h0002);
        data_in = 16'h0008;
        tick();
        read_chk("hold", 3'd1, 3'd1);

        // Dual read, distinct and same index
        do_write(3'd3, 16'hBEEF);
        do_write(3'd5, 16'h1234);
        read_chk("dual", 3'd3, 3'd5);
        read_chk("same", 3'd3, 3'd3);

        // Sweep: load all registers, clear, count busy cycles
        for (int i = 0; i < 8; i++) do_write(3'(i), 16'h1011 * 16'(i + 1));
        read_all("loaded");
        clear = 1'b1;
        tick();
        clear = 1'b0;
        cnt = 0;
        while (busy && cnt < 20) begin
            cnt++;
            if (cnt == 2) begin
                // R0 cleared by now, R1 not yet
                mdl[0] = 16'h0000;
                read_chk("partial", 3'd0, 3'd1);
            end
            write    = (cnt == 3);
            writenum = 3'd2;
            data_in  = 16'h00FF;
            clear    = (cnt == 3) || (cnt == 5);
            tick();
            write = 1'b0;
            clear = 1'b0;
        end
        check("busy_cycles", 16'(cnt), 16'd8);
        model_clear();
        read_all("swept");
        tick();
        check("busy_after", {15'd0, busy}, 16'h0000);

        // Reset during a sweep aborts it
        do_write(3'd4, 16'h4444);
        do_write(3'd7, 16'h7007);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("sweep_start", {15'd0, busy}, 16'h0001);
        for (int i = 0; i < 3; i++) tick();
        check("sweep_mid", {15'd0, busy}, 16'h0001);
        rst_n = 1'b0;
        model_clear();
        #1;
        check("abort_busy", {15'd0, busy}, 16'h0000);
        read_all("abort");
        rst_n = 1'b1;
        tick();
        check("abort_idle", {15'd0, busy}, 16'h0000);
        do_write(3'd7, 16'h0042);
        read_chk("post_abort", 3'd7, 3'd7);

        // Write-through visibility before the edge
        do_write(3'd4, 16'h1357);
        write     = 1'b1;
        writenum  = 3'd4;
        data_in   = 16'hA5A5;
        readnum_a = 3'd4;
        readnum_b = 3'd0;
`ifdef REGFILE_BYPASS_EN
        exp_q.push_back(16'hA5A5);
`else
        exp_q.push_back(16'h1357);
`endif
        #1;
        check("bypass_pre", data_out_a, exp_q.pop_front());
        tick();
        write  = 1'b0;
        mdl[4] = 16'hA5A5;
        read_chk("bypass_post", 3'd4, 3'd4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
